// File: rtl/rx_frame_if.sv
// Byte-receiver input and frame-output handshake bundle for rx_frame_ctrl.
// The master side feeds receiver bytes and acks frames; the slave side is the controller.
interface rx_frame_if #(parameter int MAX_LEN = 4);
   logic                   rx_data_ready;
   logic [7:0]             rx_data;
   logic                   rx_endofpacket;
   logic [1:0]             baud_sel;
   logic                   frame_valid;
   logic [7:0]             frame_cmd;
   logic [3:0]             frame_len;
   logic [MAX_LEN*8-1:0]   frame_payload;
   logic                   frame_ack;
   logic                   frame_err;
   logic [1:0]             err_code;

   modport master (
      output rx_data_ready, rx_data, rx_endofpacket, frame_ack,
      input  baud_sel, frame_valid, frame_cmd, frame_len, frame_payload,
             frame_err, err_code
   );

   modport slave (
      input  rx_data_ready, rx_data, rx_endofpacket, frame_ack,
      output baud_sel, frame_valid, frame_cmd, frame_len, frame_payload,
             frame_err, err_code
   );
endinterface

// File: rtl/rx_frame_ctrl.sv
// Parses received bytes into XOR-checksummed command frames, presents them with a
// valid/ack handshake, and owns the receiver baud select (changed by a config frame).
//
// state | meaning
// HUNT  | waiting for the sync byte
// CMD   | next byte is the command
// LEN   | next byte is the payload length
// DATA  | collecting payload bytes
// CHK   | next byte is the checksum
module rx_frame_ctrl #(
   parameter int         MAX_LEN      = 4,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter logic [7:0] CFG_CMD      = 8'hB0,
   parameter logic [1:0] BAUD_DEFAULT = 2'b11
) (
   input logic        clk,
   input logic        rst,
   rx_frame_if.slave  bus
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {HUNT, CMD, LEN, DATA, CHK} state_t;

   state_t                 state;
   logic [3:0]             cnt;
   logic [7:0]             chk;
   logic [7:0]             sh_cmd;
   logic [3:0]             sh_len;
   logic [MAX_LEN*8-1:0]   sh_pl;

   logic [1:0]             baud_q;
   logic                   valid_q;
   logic [7:0]             cmd_q;
   logic [3:0]             len_q;
   logic [MAX_LEN*8-1:0]   pl_q;
   logic                   err_q;
   logic [1:0]             code_q;

   logic [7:0]             b;
   assign b = bus.rx_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= HUNT;
         cnt     <= 4'd0;
         chk     <= 8'd0;
         sh_cmd  <= 8'd0;
         sh_len  <= 4'd0;
         sh_pl   <= '0;
         baud_q  <= BAUD_DEFAULT;
         valid_q <= 1'b0;
         cmd_q   <= 8'd0;
         len_q   <= 4'd0;
         pl_q    <= '0;
         err_q   <= 1'b0;
         code_q  <= 2'b00;
      end else begin
         err_q <= 1'b0;
         if (bus.frame_ack && valid_q)
            valid_q <= 1'b0;

         if (bus.rx_data_ready) begin
            unique case (state)
               HUNT: begin
                  if (b == SYNC_BYTE)
                     state <= CMD;
               end
               CMD: begin
                  sh_cmd <= b;
                  chk    <= b;
                  state  <= LEN;
               end
               LEN: begin
                  if (b > MAX_LEN_B) begin
                     err_q  <= 1'b1;
                     code_q <= 2'b01;
                     state  <= HUNT;
                  end else begin
                     // Clearing here keeps unused payload bytes zero, including len=0 frames.
                     sh_len <= b[3:0];
                     chk    <= chk ^ b;
                     cnt    <= 4'd0;
                     sh_pl  <= '0;
                     state  <= (b == 8'd0) ? CHK : DATA;
                  end
               end
               DATA: begin
                  for (int i = 0; i < MAX_LEN; i++) begin
                     if (cnt == 4'(i))
                        sh_pl[i*8 +: 8] <= b;
                  end
                  chk <= chk ^ b;
                  cnt <= cnt + 4'd1;
                  if (cnt + 4'd1 == sh_len)
                     state <= CHK;
               end
               CHK: begin
                  state <= HUNT;
                  if (b != chk) begin
                     err_q  <= 1'b1;
                     code_q <= 2'b10;
                  end else if (sh_cmd == CFG_CMD && sh_len == 4'd1) begin
                     baud_q <= sh_pl[1:0];
                  end else if (!valid_q || bus.frame_ack) begin
                     valid_q <= 1'b1;
                     cmd_q   <= sh_cmd;
                     len_q   <= sh_len;
                     pl_q    <= sh_pl;
                  end else begin
                     err_q  <= 1'b1;
                     code_q <= 2'b00;
                  end
               end
               default: state <= HUNT;
            endcase
         end else if (bus.rx_endofpacket && state != HUNT) begin
            err_q  <= 1'b1;
            code_q <= 2'b11;
            state  <= HUNT;
         end
      end
   end

   assign bus.baud_sel      = baud_q;
   assign bus.frame_valid   = valid_q;
   assign bus.frame_cmd     = cmd_q;
   assign bus.frame_len     = len_q;
   assign bus.frame_payload = pl_q;
   assign bus.frame_err     = err_q;
   assign bus.err_code      = code_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: a queue-based frame parser predicts events,
// a negedge monitor pops and compares them against what the controller presents.
module tb_rx_frame_ctrl;
   localparam int         MAX_LEN  = 4;
   localparam logic [7:0] SYNC     = 8'hA5;
   localparam logic [7:0] CFG      = 8'hB0;
   localparam logic [1:0] BAUD_DEF = 2'b11;

   typedef logic [7:0] bq_t [$];
   typedef enum int {EV_ERR = 0, EV_FRAME = 1, EV_BAUD = 2} kind_t;
   typedef struct {
      kind_t                kind;
      logic [1:0]           code;
      logic [7:0]           cmd;
      logic [3:0]           len;
      logic [MAX_LEN*8-1:0] pl;
      logic [1:0]           baud;
      int                   due;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rx_frame_if #(.MAX_LEN(MAX_LEN)) bus ();

   rx_frame_ctrl #(
      .MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .CFG_CMD(CFG), .BAUD_DEFAULT(BAUD_DEF)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference model: bytes of the frame in progress, held-frame flag, baud value.
   logic [7:0] mbuf [$];
   bit         mv    = 1'b0;
   logic [1:0] mbaud = BAUD_DEF;
   ev_t        exq [$];

   function automatic void model_step(bit dv, logic [7:0] b, bit eop, bit ack);
      ev_t        e;
      logic [7:0] x;
      bit         loaded = 1'b0;
      e.kind = EV_ERR; e.code = 2'b00; e.cmd = 8'h00; e.len = 4'h0;
      e.pl = '0; e.baud = 2'b00; e.due = cyc + 1;
      if (dv) begin
         if (mbuf.size() == 0) begin
            if (b == SYNC) mbuf.push_back(b);
         end else begin
            mbuf.push_back(b);
            if (mbuf.size() == 3 && int'(b) > MAX_LEN) begin
               e.code = 2'b01; exq.push_back(e); mbuf.delete();
            end else if (mbuf.size() >= 4 && mbuf.size() == 4 + int'(mbuf[2])) begin
               x = 8'h00;
               for (int i = 1; i < mbuf.size() - 1; i++) x ^= mbuf[i];
               if (x != b) begin
                  e.code = 2'b10; exq.push_back(e);
               end else if (mbuf[1] == CFG && mbuf[2] == 8'd1) begin
                  if (mbuf[3][1:0] != mbaud) begin
                     e.kind = EV_BAUD; e.baud = mbuf[3][1:0]; exq.push_back(e);
                  end
                  mbaud = mbuf[3][1:0];
               end else if (!mv || ack) begin
                  e.kind = EV_FRAME; e.cmd = mbuf[1]; e.len = mbuf[2][3:0];
                  for (int i = 0; i < int'(mbuf[2]); i++) e.pl[8*i +: 8] = mbuf[3+i];
                  exq.push_back(e);
                  loaded = 1'b1;
               end else begin
                  e.code = 2'b00; exq.push_back(e);
               end
               mbuf.delete();
            end
         end
      end else if (eop && mbuf.size() != 0) begin
         e.code = 2'b11; exq.push_back(e); mbuf.delete();
      end
      if (loaded) mv = 1'b1;
      else if (ack) mv = 1'b0;
   endfunction

   // Monitor
   bit                   prev_valid = 1'b0;
   bit                   prev_ack   = 1'b0;
   logic [1:0]           prev_baud  = BAUD_DEF;
   logic [7:0]           h_cmd = 8'h00;
   logic [3:0]           h_len = 4'h0;
   logic [MAX_LEN*8-1:0] h_pl  = '0;

   function automatic bit pop_ev(kind_t k, output ev_t e);
      if (exq.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", int'(k), cyc);
         return 1'b0;
      end
      e = exq.pop_front();
      chk("event_kind", 64'(int'(k)), 64'(int'(e.kind)));
      chk("event_latency", 64'(cyc), 64'(e.due));
      return e.kind == k;
   endfunction

   always @(negedge clk) begin
      ev_t e;
      if (rst) begin
         chk("err_during_reset", bus.frame_err, 1'b0);
         prev_valid = 1'b0;
         prev_ack   = 1'b0;
         prev_baud  = bus.baud_sel;
      end else begin
         if (bus.frame_err) begin
            if (pop_ev(EV_ERR, e)) chk("err_code", bus.err_code, e.code);
         end
         if (prev_valid && !prev_ack)
            chk("valid_hold", bus.frame_valid, 1'b1);
         if (bus.frame_valid && (!prev_valid || prev_ack)) begin
            if (pop_ev(EV_FRAME, e)) begin
               chk("frame_cmd", bus.frame_cmd, e.cmd);
               chk("frame_len", bus.frame_len, e.len);
               chk("frame_payload", bus.frame_payload, e.pl);
            end
            h_cmd = bus.frame_cmd; h_len = bus.frame_len; h_pl = bus.frame_payload;
         end else if (bus.frame_valid) begin
            chk("held_cmd", bus.frame_cmd, h_cmd);
            chk("held_len", bus.frame_len, h_len);
            chk("held_payload", bus.frame_payload, h_pl);
         end
         if (bus.baud_sel != prev_baud) begin
            if (pop_ev(EV_BAUD, e)) chk("baud_sel", bus.baud_sel, e.baud);
         end
         while (exq.size() > 0 && exq[0].due < cyc) begin
            e = exq.pop_front();
            checks++; errors++;
            $display("FAIL missed_event: got nothing expected kind %0d due %0d (cycle %0d)",
                     int'(e.kind), e.due, cyc);
         end
         prev_valid = bus.frame_valid;
         prev_ack   = bus.frame_ack;
         prev_baud  = bus.baud_sel;
      end
   end

   // Driver
   int ack_pct = 0;
   int eop_pct = 0;

   function automatic bit rnd_pct(int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   task automatic drive(bit dv, logic [7:0] b, bit eop, bit ack);
      bus.rx_data_ready  = dv;
      bus.rx_data        = dv ? b : 8'($urandom);
      bus.rx_endofpacket = eop;
      bus.frame_ack      = ack;
      model_step(dv, b, eop, ack);
      @(posedge clk); #1;
      bus.rx_data_ready  = 1'b0;
      bus.rx_endofpacket = 1'b0;
      bus.frame_ack      = 1'b0;
   endtask

   task automatic send(input bq_t q, input bit ack_last);
      for (int i = 0; i < q.size(); i++)
         drive(1'b1, q[i], rnd_pct(eop_pct), (ack_last && i == q.size() - 1) ? 1'b1 : rnd_pct(ack_pct));
   endtask

   task automatic idle(int n, bit ack);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, ack);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mbuf.delete();
      mv    = 1'b0;
      mbaud = BAUD_DEF;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic bq_t mk_frame(logic [7:0] cmd, int len, bit bad_chk);
      bq_t        q;
      logic [7:0] x, d;
      q.push_back(SYNC); q.push_back(cmd); q.push_back(8'(len));
      x = cmd ^ 8'(len);
      for (int i = 0; i < len; i++) begin
         d = 8'($urandom); q.push_back(d); x ^= d;
      end
      if (bad_chk) x ^= 8'(1 << $urandom_range(7));
      q.push_back(x);
      return q;
   endfunction

   bq_t good;
   initial begin
      bq_t q, t;
      int  sel, k;
      bus.rx_data_ready = 1'b0; bus.rx_data = 8'h00;
      bus.rx_endofpacket = 1'b0; bus.frame_ack = 1'b0;
      good = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_baud", bus.baud_sel, BAUD_DEF);
      chk("rst_valid", bus.frame_valid, 1'b0);
      chk("rst_err", bus.frame_err, 1'b0);
      chk("rst_err_code", bus.err_code, 2'b00);
      chk("rst_cmd", bus.frame_cmd, 8'h00);
      chk("rst_len", bus.frame_len, 4'h0);
      chk("rst_payload", bus.frame_payload, '0);
      rst = 1'b0;

      // Basic frame, held until ack
      send(good, 1'b0);
      chk("valid_after_chk", bus.frame_valid, 1'b1);
      idle(3, 1'b0);
      chk("hold_cmd", bus.frame_cmd, 8'h10);
      chk("hold_payload", bus.frame_payload, 32'h0000_4433);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      chk("valid_after_ack", bus.frame_valid, 1'b0);

      // Baud config frame
      q = '{8'hA5, 8'hB0, 8'h01, 8'h02, 8'hB3};
      send(q, 1'b0);
      chk("baud_cfg", bus.baud_sel, 2'b10);
      chk("cfg_not_presented", bus.frame_valid, 1'b0);

      // Error cases, each followed by a good frame
      q = '{8'hA5, 8'h10, 8'h05};
      send(q, 1'b0); idle(1, 1'b0); send(good, 1'b0); idle(1, 1'b1);
      q = '{8'hA5, 8'h10, 8'h01, 8'h33, 8'h00};
      send(q, 1'b0); idle(1, 1'b0); send(good, 1'b0); idle(1, 1'b1);
      q = '{8'hA5, 8'h10, 8'h02, 8'h33};
      send(q, 1'b0); drive(1'b0, 8'h00, 1'b1, 1'b0); idle(1, 1'b0);
      send(good, 1'b0); idle(1, 1'b1);

      // Overflow, then ack colliding with completion
      q = '{8'hA5, 8'h20, 8'h01, 8'h07, 8'h26};
      t = '{8'hA5, 8'h30, 8'h00, 8'h30};
      send(q, 1'b0); send(t, 1'b0); idle(2, 1'b0);
      chk("overflow_kept_cmd", bus.frame_cmd, 8'h20);
      idle(1, 1'b1);
      send(q, 1'b0); send(t, 1'b1); idle(1, 1'b0);
      chk("collision_loaded_cmd", bus.frame_cmd, 8'h30);
      idle(1, 1'b1);

      // Noise before sync
      q = '{8'h00, 8'hFF, 8'h5A};
      send(q, 1'b0); send(good, 1'b0); idle(1, 1'b1);

      // Reset mid-frame
      q = '{8'hA5, 8'h10};
      send(q, 1'b0);
      do_reset();
      chk("baud_after_reset", bus.baud_sel, 2'b11);
      chk("valid_after_reset", bus.frame_valid, 1'b0);
      send(good, 1'b0); idle(1, 1'b1);

      // Randomized traffic
      ack_pct = 40;
      eop_pct = 5;
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(99));
         if (sel < 45) begin
            send(mk_frame(8'($urandom), int'($urandom_range(MAX_LEN)), 1'b0), 1'b0);
         end else if (sel < 55) begin
            send(mk_frame(CFG, 1, 1'b0), 1'b0);
         end else if (sel < 65) begin
            send(mk_frame(8'($urandom), int'($urandom_range(MAX_LEN)), 1'b1), 1'b0);
         end else if (sel < 73) begin
            q = '{SYNC, 8'($urandom), 8'($urandom_range(MAX_LEN + 1, 255))};
            send(q, 1'b0);
         end else if (sel < 85) begin
            t = mk_frame(8'($urandom), int'($urandom_range(MAX_LEN)), 1'b0);
            k = int'($urandom_range(1, t.size() - 1));
            q.delete();
            for (int i = 0; i < k; i++) q.push_back(t[i]);
            send(q, 1'b0);
            drive(1'b0, 8'h00, 1'b1, rnd_pct(ack_pct));
         end else begin
            q.delete();
            k = int'($urandom_range(1, 4));
            for (int i = 0; i < k; i++) q.push_back(8'($urandom_range(8'hA6, 8'hFF + 8'hA5 - 1)) == SYNC ? 8'h00 : 8'($urandom_range(0, 8'hA4)));
            send(q, 1'b0);
         end
         k = int'($urandom_range(2));
         for (int i = 0; i < k; i++) drive(1'b0, 8'h00, rnd_pct(30), rnd_pct(ack_pct));
      end

      idle(4, 1'b1);
      chk("scoreboard_drained", 64'(exq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

endmodule
